// File: rtl/ysyx_23060171_wbu_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060171_wbu_if
// Bundles every signal of the write-back unit except the clock and reset.
//
//   Upstream (EXU) handshake : in_valid / in_ready plus the in_* payload
//                              (pc, result, rd, rd_wen, is_load, load_op)
//   Memory read channel      : mem_rvalid / mem_rready / mem_rdata
//   Register file write port : gpr_wen / gpr_waddr / gpr_wdata
//   Retirement report        : commit_valid / commit_pc
//
// Modports:
//   master - the environment around the WBU (EXU, memory and observers).
//   slave  - the WBU itself.
// ---------------------------------------------------------------------------
interface ysyx_23060171_wbu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    // Upstream result channel
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_pc;
    logic [DATA_WIDTH-1:0] in_result;
    logic [ADDR_WIDTH-1:0] in_rd;
    logic                  in_rd_wen;
    logic                  in_is_load;
    logic [2:0]            in_load_op;

    // Memory read-data channel
    logic                  mem_rvalid;
    logic                  mem_rready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Register file write port
    logic                  gpr_wen;
    logic [ADDR_WIDTH-1:0] gpr_waddr;
    logic [DATA_WIDTH-1:0] gpr_wdata;

    // Retirement report
    logic                  commit_valid;
    logic [31:0]           commit_pc;

    modport master (
        output in_valid, in_pc, in_result, in_rd, in_rd_wen, in_is_load, in_load_op,
        output mem_rvalid, mem_rdata,
        input  in_ready, mem_rready,
        input  gpr_wen, gpr_waddr, gpr_wdata,
        input  commit_valid, commit_pc
    );

    modport slave (
        input  in_valid, in_pc, in_result, in_rd, in_rd_wen, in_is_load, in_load_op,
        input  mem_rvalid, mem_rdata,
        output in_ready, mem_rready,
        output gpr_wen, gpr_waddr, gpr_wdata,
        output commit_valid, commit_pc
    );
endinterface

// File: rtl/ysyx_23060171_wbu.sv
// ---------------------------------------------------------------------------
// ysyx_23060171_wbu
// Write-back unit. Accepts one EXU result per transfer, waits for load data
// when the instruction is a load, extends the loaded byte/halfword/word, then
// writes the register file and reports the retirement for exactly one cycle.
//
// Ports:
//   clk  - single clock.
//   rst  - asynchronous, active-high reset.
//   bus  - ysyx_23060171_wbu_if.slave: upstream handshake and payload,
//          memory read-data channel, GPR write port, commit report.
//
// Timing:
//   Non-load accepted at edge N -> write/commit visible during cycle N+1.
//   Load -> write/commit visible during the cycle after the edge that
//   samples mem_rvalid. A new transfer is accepted while a write is shown,
//   so non-loads retire at one per cycle.
//
// All gpr_* / commit_* outputs come straight from flops; only in_ready and
// mem_rready are decoded (from the state register).
// ---------------------------------------------------------------------------
module ysyx_23060171_wbu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_23060171_wbu_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic in_ready_c;
    logic mem_rready_c;
    logic take;       // upstream transfer happens at the coming edge
    logic load_done;  // load data arrives at the coming edge

    // Load instruction held while the memory answer is outstanding
    logic [31:0]           pc_p0;
    logic [ADDR_WIDTH-1:0] rd_p0;
    logic                  rd_wen_p0;
    logic                  is_load_p0;
    logic [2:0]            load_op_p0;
    logic [1:0]            off_p0;

    // Registered write-back / commit outputs
    logic                  wen_p1;
    logic [ADDR_WIDTH-1:0] waddr_p1;
    logic [DATA_WIDTH-1:0] wdata_p1;
    logic                  cvld_p1;
    logic [31:0]           cpc_p1;

    // Select the addressed byte/halfword of the aligned word and extend it.
    // Unknown funct3 codes fall back to a full-word load.
    function automatic logic [DATA_WIDTH-1:0] load_ext(
        input logic [2:0]            op,
        input logic [1:0]            off,
        input logic [DATA_WIDTH-1:0] word
    );
        logic signed [7:0]     b;
        logic signed [15:0]    h;
        logic [DATA_WIDTH-1:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            3'b000:  r = {{(DATA_WIDTH-8){b[7]}}, b};
            3'b001:  r = {{(DATA_WIDTH-16){h[15]}}, h};
            3'b100:  r = {{(DATA_WIDTH-8){1'b0}}, b};
            3'b101:  r = {{(DATA_WIDTH-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // ---- control: state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- control: next state and handshake decode ----
    always_comb begin
        state_nxt    = state;
        in_ready_c   = 1'b0;
        mem_rready_c = 1'b0;
        take         = 1'b0;
        load_done    = 1'b0;
        case (state)
            IDLE, WRITE: begin
                // WRITE lasts one cycle; it either hands over to the next
                // instruction or falls back to IDLE.
                in_ready_c = 1'b1;
                take       = bus.in_valid;
                if (bus.in_valid) begin
                    state_nxt = bus.in_is_load ? WAIT_MEM : WRITE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT_MEM: begin
                mem_rready_c = 1'b1;
                load_done    = bus.mem_rvalid;
                if (bus.mem_rvalid) begin
                    state_nxt = WRITE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.mem_rready = mem_rready_c;

    // ---- stage p0: capture the accepted instruction ----
    always_ff @(posedge clk) begin
        if (take) begin
            pc_p0      <= bus.in_pc;
            rd_p0      <= bus.in_rd;
            rd_wen_p0  <= bus.in_rd_wen;
            is_load_p0 <= bus.in_is_load;
            load_op_p0 <= bus.in_load_op;
            off_p0     <= bus.in_result[1:0];
        end
    end

    // ---- stage p1: write-back / commit registers ----
    // Loaded exactly on the edges that enter WRITE, so the enables pulse for
    // one cycle and address/data/pc hold their last values otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
            cvld_p1  <= 1'b0;
            cpc_p1   <= '0;
        end else begin
            wen_p1  <= 1'b0;
            cvld_p1 <= 1'b0;
            if (take && !bus.in_is_load) begin
                wen_p1   <= bus.in_rd_wen && (bus.in_rd != '0);
                waddr_p1 <= bus.in_rd;
                wdata_p1 <= bus.in_result;
                cvld_p1  <= 1'b1;
                cpc_p1   <= bus.in_pc;
            end else if (load_done && is_load_p0) begin
                wen_p1   <= rd_wen_p0 && (rd_p0 != '0);
                waddr_p1 <= rd_p0;
                wdata_p1 <= load_ext(load_op_p0, off_p0, bus.mem_rdata);
                cvld_p1  <= 1'b1;
                cpc_p1   <= pc_p0;
            end
        end
    end

    assign bus.gpr_wen      = wen_p1;
    assign bus.gpr_waddr    = waddr_p1;
    assign bus.gpr_wdata    = wdata_p1;
    assign bus.commit_valid = cvld_p1;
    assign bus.commit_pc    = cpc_p1;

endmodule
